// File: rtl/ising_pkg.sv
// Shared types and constants for the Ising sweep engine and related annealing blocks.
package ising_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EVAL,
    COMMIT,
    FIN
  } state_t;

  localparam int DE_W   = 5;
  localparam int RAND_W = 12;
  localparam int LFSR_W = 16;

  localparam logic SPIN_UP = 1'b1;
  localparam logic SPIN_DN = 1'b0;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;

  // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when step is high.
// A zero seed would lock the register, so it is replaced by the default seed.
import ising_pkg::*;

module lfsr16 (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] seed_eff;

  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

  // Load the seed on reset, otherwise advance once per step request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed_eff;
    end else if (step) begin
      state <= lfsr_advance(state);
    end
  end

endmodule

// File: rtl/ising_sweep_engine.sv
// Sequential Metropolis sweep over an on-chip N x N Ising lattice with periodic
// boundaries. Each site takes FETCH / EVAL / COMMIT; the accept decision comes from
// an external combinational LUT driven during EVAL.
// Optional feature: define MAG_TRACK_EN to keep a running signed magnetization;
// without it the magnetization port is tied to zero.
import ising_pkg::*;

module ising_sweep_engine #(
  parameter int          N    = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               sweeps,
  output logic                     busy,
  output logic                     done,
  output logic signed [DE_W-1:0]   lut_dE,
  output logic [RAND_W-1:0]        lut_random,
  output logic                     lut_enable,
  input  logic                     lut_accept,
  input  logic [2*$clog2(N)-1:0]   rd_addr,
  output logic                     rd_spin,
  output logic signed [15:0]       magnetization
);

  localparam int AW    = $clog2(N);
  localparam int SITES = N * N;
  localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

  state_t state_q, state_d;

  logic [AW-1:0]     row_q, col_q;
  logic [7:0]        sweeps_q, sweep_cnt_q;
  logic [SITES-1:0]  spins_q;
  logic              accept_p1;
  logic [LFSR_W-1:0] lfsr_state;
  logic [3:0]        lfsr_hi_unused;

  logic [2*AW-1:0]   site_idx;
  logic [AW-1:0]     row_up, row_dn, col_lf, col_rt;
  logic [2:0]        nb_ones;
  logic              last_site;
  logic              last_sweep;
  logic              flip_now;

  // dE = s * (2*ones - 4), with s = +1 for a set bit and -1 for a clear bit
  function automatic logic signed [DE_W-1:0] energy_delta(input logic site, input logic [2:0] ones);
    logic signed [DE_W-1:0] nsum;
    nsum = $signed({1'b0, ones, 1'b0}) - 5'sd4;
    return (site == SPIN_UP) ? nsum : -nsum;
  endfunction

  // Neighbour addressing; log2(N)-bit arithmetic gives the periodic wrap
  always_comb begin
    site_idx = {row_q, col_q};
    row_up   = row_q - AW'(1);
    row_dn   = row_q + AW'(1);
    col_lf   = col_q - AW'(1);
    col_rt   = col_q + AW'(1);
    nb_ones  = 3'(spins_q[{row_up, col_q}]) + 3'(spins_q[{row_dn, col_q}])
             + 3'(spins_q[{row_q, col_lf}]) + 3'(spins_q[{row_q, col_rt}]);
    last_site  = (row_q == IDX_LAST) && (col_q == IDX_LAST);
    last_sweep = (sweep_cnt_q + 8'd1) == sweeps_q;
    flip_now   = (state_q == COMMIT) && accept_p1;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (sweeps == 8'd0) ? FIN : FETCH;
      FETCH:   state_d = EVAL;
      EVAL:    state_d = COMMIT;
      COMMIT:  state_d = (last_site && last_sweep) ? FIN : FETCH;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, registered dE, registered LUT decision and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      lut_dE      <= '0;
      accept_p1   <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= (state_q == FIN);
      case (state_q)
        IDLE: begin
          if (start) begin
            sweeps_q    <= sweeps;
            row_q       <= '0;
            col_q       <= '0;
            sweep_cnt_q <= '0;
          end
        end
        FETCH: lut_dE <= energy_delta(spins_q[site_idx], nb_ones);
        EVAL:  accept_p1 <= lut_accept;
        COMMIT: begin
          col_q <= col_q + AW'(1);
          if (col_q == IDX_LAST) begin
            row_q <= row_q + AW'(1);
            if (row_q == IDX_LAST) sweep_cnt_q <= sweep_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Spin lattice: all +1 on reset, accepted flips committed in COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      spins_q <= {SITES{SPIN_UP}};
    end else if (flip_now) begin
      spins_q[site_idx] <= ~spins_q[site_idx];
    end
  end

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (state_q == COMMIT),
    .seed  (SEED),
    .state (lfsr_state)
  );

  assign lfsr_hi_unused = lfsr_state[LFSR_W-1:RAND_W];
  assign lut_random     = lfsr_state[RAND_W-1:0];
  assign lut_enable     = (state_q == EVAL);
  assign busy           = (state_q != IDLE);
  assign rd_spin        = spins_q[rd_addr];

`ifdef MAG_TRACK_EN
  logic signed [15:0] mag_q;

  // Running sum of spins: a 1->0 flip removes 2, a 0->1 flip adds 2
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= 16'(SITES);
    end else if (flip_now) begin
      mag_q <= (spins_q[site_idx] == SPIN_UP) ? mag_q - 16'sd2 : mag_q + 16'sd2;
    end
  end

  assign magnetization = mag_q;
`else
  assign magnetization = '0;
`endif

endmodule

// File: tb/tb_ising_sweep_engine.sv
// Directed bench for ising_sweep_engine at N=4 with a bit-level lattice/LFSR model.
module tb_ising_sweep_engine;

  localparam int N     = 4;
  localparam int SITES = N * N;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        sweeps;
  logic              busy;
  logic              done;
  logic signed [4:0] lut_dE;
  logic [11:0]       lut_random;
  logic              lut_enable;
  logic              lut_accept;
  logic [3:0]        rd_addr;
  logic              rd_spin;
  logic signed [15:0] magnetization;

  int n_assert = 0;
  int n_fail   = 0;

  bit          mspin [SITES];
  logic [15:0] mlfsr;
  int          msite;

  ising_sweep_engine #(.N(N), .SEED(16'hACE1)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sweeps        (sweeps),
    .busy          (busy),
    .done          (done),
    .lut_dE        (lut_dE),
    .lut_random    (lut_random),
    .lut_enable    (lut_enable),
    .lut_accept    (lut_accept),
    .rd_addr       (rd_addr),
    .rd_spin       (rd_spin),
    .magnetization (magnetization)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic signed [4:0] model_de(input int idx);
    int r, c, ones, s;
    r = idx / N;
    c = idx % N;
    ones = int'(mspin[((r + N - 1) % N) * N + c]) + int'(mspin[((r + 1) % N) * N + c])
         + int'(mspin[r * N + (c + N - 1) % N]) + int'(mspin[r * N + (c + 1) % N]);
    s = 2 * ones - 4;
    if (!mspin[idx]) s = -s;
    return 5'(s);
  endfunction

  function automatic int model_mag();
    int m;
    m = 0;
`ifdef MAG_TRACK_EN
    for (int i = 0; i < SITES; i++) m += mspin[i] ? 1 : -1;
`endif
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SITES; i++) mspin[i] = 1'b1;
    mlfsr = 16'hACE1;
    msite = 0;
  endtask

  task automatic check_lattice(input string tag);
    for (int i = 0; i < SITES; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      check({tag, "_spin"}, 32'(rd_spin), 32'(mspin[i]));
    end
    check({tag, "_mag"}, 32'(magnetization), 32'(model_mag()));
    @(posedge clk); #1;
  endtask

  // Start at cycle 0, track every EVAL against the model, stop at done or timeout
  task automatic run(input logic [7:0] nsw, input logic acc, input int restart_at,
                     output int done_cyc, output int evals,
                     output logic signed [4:0] de0, output logic signed [4:0] de1,
                     output logic [11:0] rnd1);
    int idx;
    lut_accept = acc;
    sweeps     = nsw;
    start      = 1'b1;
    msite      = 0;
    done_cyc   = -1;
    evals      = 0;
    de0        = 'x;
    de1        = 'x;
    rnd1       = 'x;
    for (int cyc = 1; cyc <= 3 * SITES * int'(nsw) + 10; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == restart_at);
      if (cyc == 1) check("busy_cycle1", 32'(busy), 32'd1);
      if (lut_enable) begin
        idx = msite % SITES;
        check("eval_dE", 32'(lut_dE), 32'(model_de(idx)));
        check("eval_random", 32'(lut_random), 32'(mlfsr[11:0]));
        if (evals == 0) de0 = lut_dE;
        if (evals == 1) begin
          de1  = lut_dE;
          rnd1 = lut_random;
        end
        if (acc) mspin[idx] = ~mspin[idx];
        mlfsr = model_lfsr_next(mlfsr);
        msite++;
        evals++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int done_cyc, evals;
    logic signed [4:0] de0, de1;
    logic [11:0] rnd1;

    rst        = 1'b1;
    start      = 1'b0;
    sweeps     = 8'd0;
    lut_accept = 1'b0;
    rd_addr    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_enable", 32'(lut_enable), 32'd0);
    check("rst_dE", 32'(lut_dE), 32'd0);
    check("rst_random", 32'(lut_random), 32'h0CE1);
`ifdef MAG_TRACK_EN
    check("rst_mag", 32'(magnetization), 32'd16);
`else
    check("rst_mag", 32'(magnetization), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // One sweep, never accept, extra start pulse at cycle 10
    run(8'd1, 1'b0, 10, done_cyc, evals, de0, de1, rnd1);
    check("rej_done_cycle", 32'(done_cyc), 32'd50);
    check("rej_eval_count", 32'(evals), 32'd16);
    check("rej_dE_first", 32'(de0), 32'd4);
    check("rand_second_eval", 32'(rnd1), 32'h09C3);
    check("rej_lfsr_after", 32'(lut_random), 32'(mlfsr[11:0]));
    check_lattice("rej");

    // One sweep, always accept, start pulse during FIN at cycle 49
    run(8'd1, 1'b1, 49, done_cyc, evals, de0, de1, rnd1);
    check("acc_done_cycle", 32'(done_cyc), 32'd50);
    check("acc_eval_count", 32'(evals), 32'd16);
    check("acc_dE_site00", 32'(de0), 32'd4);
    check("acc_dE_site01", 32'(de1), 32'd2);
    check("acc_lfsr_after", 32'(lut_random), 32'(mlfsr[11:0]));
    check_lattice("acc");

    // Zero sweeps: immediate finish, lattice untouched
    run(8'd0, 1'b1, -1, done_cyc, evals, de0, de1, rnd1);
    check("zero_done_cycle", 32'(done_cyc), 32'd2);
    check("zero_eval_count", 32'(evals), 32'd0);
    check_lattice("zero");

    // Reset mid-run at cycle 20
    model_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    lut_accept = 1'b1;
    sweeps     = 8'd1;
    start      = 1'b1;
    rd_addr    = 4'd0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 20) begin
        check("mid_site00_flipped", 32'(rd_spin), 32'd0);
        rst = 1'b1;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_dE", 32'(lut_dE), 32'd0);
    check("mid_rst_random", 32'(lut_random), 32'h0CE1);
`ifdef MAG_TRACK_EN
    check("mid_rst_mag", 32'(magnetization), 32'd16);
`else
    check("mid_rst_mag", 32'(magnetization), 32'd0);
`endif
    check_lattice("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
